// File: rtl/n_demultiplex_buf_pkg.sv
// Shared definitions for the buffered 1-to-2 demultiplexer: channel select codes
// and the width helper used to size pointers and occupancy counts.
package n_demultiplex_buf_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/n_demultiplex_buf_if.sv
// Handshake bundle for the demultiplexer: one valid/ready input stream and two
// valid/ready output channels with their occupancy counts.
interface n_demultiplex_buf_if
  import n_demultiplex_buf_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 2
);

  logic                          s_valid;
  logic                          s_ready;
  logic                          s_sel;
  logic [N-1:0]                  s_data;
  logic                          a_valid;
  logic                          a_ready;
  logic [N-1:0]                  a_data;
  logic [clog2(DEPTH+1)-1:0]     a_count;
  logic                          b_valid;
  logic                          b_ready;
  logic [N-1:0]                  b_data;
  logic [clog2(DEPTH+1)-1:0]     b_count;

  modport master (
    output s_valid, s_sel, s_data, a_ready, b_ready,
    input  s_ready, a_valid, a_data, a_count, b_valid, b_data, b_count
  );

  modport slave (
    input  s_valid, s_sel, s_data, a_ready, b_ready,
    output s_ready, a_valid, a_data, a_count, b_valid, b_data, b_count
  );

endinterface

// File: rtl/n_demultiplex_buf_chan_fifo.sv
// Per-channel FIFO with a registered head word; the head register is refreshed
// on push into an empty queue or on pop, so dout never sees din combinationally.
module chan_fifo
  import n_demultiplex_buf_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [N-1:0]              din,
  input  logic                      pop,
  output logic [N-1:0]              dout,
  output logic [clog2(DEPTH+1)-1:0] count,
  output logic                      full,
  output logic                      empty
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH+1);

  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_next;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_next = rd_ptr + 1'b1;

  // With more than one entry the next head is already stored; otherwise it is the incoming word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_next;
      if (do_push && !do_pop) count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
      if (do_pop && count > CW'(1)) dout <= mem[rd_next];
      else if (do_push && (empty || (do_pop && count == CW'(1)))) dout <= din;
    end
  end

endmodule

// File: rtl/n_demultiplex_buf.sv
// Buffered N-bit 1-to-2 demultiplexer: steers each accepted word into channel A
// or B, each backed by its own FIFO so one stalled consumer never blocks the other.
module n_demultiplex_buf
  import n_demultiplex_buf_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  n_demultiplex_buf_if.slave  bus
);

  logic push_a;
  logic push_b;
  logic full_a;
  logic full_b;
  logic empty_a;
  logic empty_b;

  // Readiness depends only on the selected channel's fullness, never on a same-cycle pop.
  assign bus.s_ready = rst & ~((bus.s_sel == SEL_B) ? full_b : full_a);
  assign push_a      = bus.s_valid & bus.s_ready & (bus.s_sel == SEL_A);
  assign push_b      = bus.s_valid & bus.s_ready & (bus.s_sel == SEL_B);
  assign bus.a_valid = ~empty_a;
  assign bus.b_valid = ~empty_b;

  chan_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (push_a),
    .din   (bus.s_data),
    .pop   (bus.a_ready),
    .dout  (bus.a_data),
    .count (bus.a_count),
    .full  (full_a),
    .empty (empty_a)
  );

  chan_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (push_b),
    .din   (bus.s_data),
    .pop   (bus.b_ready),
    .dout  (bus.b_data),
    .count (bus.b_count),
    .full  (full_b),
    .empty (empty_b)
  );

endmodule

// File: tb/tb_n_demultiplex_buf.sv
// Self-checking bench for n_demultiplex_buf: directed scenarios plus random traffic,
// all compared against a queue-based model of the two channels.
module tb_n_demultiplex_buf;

  localparam int N     = 32;
  localparam int DEPTH = 2;

  logic clk;
  logic rst;
  int   num_vectors;
  int   num_miscompares;

  logic [N-1:0] qa [$];
  logic [N-1:0] qb [$];
  logic [N-1:0] last_a;
  logic [N-1:0] last_b;

  n_demultiplex_buf_if #(.N(N), .DEPTH(DEPTH)) bus ();

  n_demultiplex_buf #(.N(N), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    num_vectors++;
    if (actual !== expected) begin
      num_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic sel, input logic [N-1:0] d,
                               input logic ar, input logic br);
    bus.s_valid = v;
    bus.s_sel   = sel;
    bus.s_data  = d;
    bus.a_ready = ar;
    bus.b_ready = br;
  endtask

  task automatic modelClear();
    qa.delete();
    qb.delete();
    last_a = '0;
    last_b = '0;
  endtask

  // Compares every output against what the queues say the channels should show now.
  task automatic checkAll();
    logic exp_ready;
    exp_ready = rst && ((bus.s_sel == 1'b1) ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
    checkOutput("s_ready", 64'(bus.s_ready), 64'(exp_ready));
    checkOutput("a_valid", 64'(bus.a_valid), 64'(qa.size() != 0));
    checkOutput("a_count", 64'(bus.a_count), 64'(qa.size()));
    checkOutput("a_data",  64'(bus.a_data),  64'((qa.size() != 0) ? qa[0] : last_a));
    checkOutput("b_valid", 64'(bus.b_valid), 64'(qb.size() != 0));
    checkOutput("b_count", 64'(bus.b_count), 64'(qb.size()));
    checkOutput("b_data",  64'(bus.b_data),  64'((qb.size() != 0) ? qb[0] : last_b));
  endtask

  task automatic modelEdge(input logic v, input logic sel, input logic [N-1:0] d,
                           input logic ar, input logic br);
    logic push_ok;
    logic pop_a;
    logic pop_b;
    if (!rst) begin
      modelClear();
      return;
    end
    push_ok = v && (sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
    pop_a   = ar && (qa.size() != 0);
    pop_b   = br && (qb.size() != 0);
    if (pop_a) void'(qa.pop_front());
    if (pop_b) void'(qb.pop_front());
    if (push_ok && !sel) qa.push_back(d);
    if (push_ok && sel)  qb.push_back(d);
    if (qa.size() != 0) last_a = qa[0];
    if (qb.size() != 0) last_b = qb[0];
  endtask

  task automatic runCycle(input logic v, input logic sel, input logic [N-1:0] d,
                          input logic ar, input logic br);
    applyStimulus(v, sel, d, ar, br);
    #1;
    checkAll();
    @(posedge clk);
    modelEdge(v, sel, d, ar, br);
    @(negedge clk);
  endtask

  initial begin
    num_vectors     = 0;
    num_miscompares = 0;
    rst = 1'b0;
    modelClear();
    applyStimulus(1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b1);
    @(negedge clk);

    // Reset held with s_valid high
    for (int i = 0; i < 3; i++) runCycle(1'b1, i[0], 32'hA5A5A5A5, 1'b1, 1'b1);
    rst = 1'b1;

    // Routing
    runCycle(1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1);
    runCycle(1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1);
    runCycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    runCycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Full on A, B still accepts
    runCycle(1'b1, 1'b0, 32'h000000A1, 1'b0, 1'b0);
    runCycle(1'b1, 1'b0, 32'h000000A2, 1'b0, 1'b0);
    runCycle(1'b1, 1'b0, 32'h000000A3, 1'b0, 1'b0);
    runCycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    runCycle(1'b1, 1'b1, 32'h000000B1, 1'b0, 1'b0);

    // Full with same-cycle pop: push refused, count drops
    runCycle(1'b1, 1'b0, 32'h000000A4, 1'b1, 1'b1);
    runCycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    runCycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Order and pointer wrap on A
    for (int i = 1; i <= 8; i++) runCycle(1'b1, 1'b0, N'(i), 1'b1, 1'b1);
    runCycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    runCycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Reset mid-stream with both channels full
    runCycle(1'b1, 1'b0, 32'h11111111, 1'b0, 1'b0);
    runCycle(1'b1, 1'b0, 32'h22222222, 1'b0, 1'b0);
    runCycle(1'b1, 1'b1, 32'h33333333, 1'b0, 1'b0);
    runCycle(1'b1, 1'b1, 32'h44444444, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    modelClear();
    #1;
    checkAll();
    @(negedge clk);
    runCycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) runCycle(1'b0, i[0], 32'h0, 1'b1, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      runCycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), N'($urandom()),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule
